prog_ctr_seq: RTL and testbench

Fetch-stage program counter sequencer. It sits directly downstream of the branch-target lookup table: it consumes the 8-bit target the table produces and drives the instruction-memory address.
- Controls start, run and halt of each program.
- Applies stalls.
- Redirects the PC on taken branches, relocating the target by a per-program base.
- Counts executed cycles for the test harness.

---
 rtl/prog_ctr_pkg.sv | 21 ++
 rtl/sat_counter.sv | 18 +
 rtl/prog_ctr_seq.sv | 112 +++++++++++
 tb/tb_prog_ctr_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types and defaults for the fetch-stage program counter sequencer.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int PC_W_DEF       = 10;
  localparam int CNT_W_DEF      = 16;
  localparam int PROG1_BASE_DEF = 0;
  localparam int PROG2_BASE_DEF = 256;
  localparam int PROG3_BASE_DEF = 512;

  // ProgSel encoding; 0 is not a real program and falls back to program 1.
  localparam logic [1:0] SEL_P1 = 2'd1;
  localparam logic [1:0] SEL_P2 = 2'd2;
  localparam logic [1:0] SEL_P3 = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/prog_ctr_seq.sv
// Fetch-stage PC sequencer: launch/abort/halt control, stalls, base-relative
// branch redirect and a saturating RUN-cycle counter.
module prog_ctr_seq
  import prog_ctr_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int PROG1_BASE = PROG1_BASE_DEF,
  parameter int PROG2_BASE = PROG2_BASE_DEF,
  parameter int PROG3_BASE = PROG3_BASE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [7:0]       Target,
  input  logic             HaltReq,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             FetchEn,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam logic [PC_W-1:0] BASE1 = PC_W'(PROG1_BASE);
  localparam logic [PC_W-1:0] BASE2 = PC_W'(PROG2_BASE);
  localparam logic [PC_W-1:0] BASE3 = PC_W'(PROG3_BASE);

  state_t          state, state_nxt;
  logic            start_q;
  logic [PC_W-1:0] base, base_nxt, pc_nxt, sel_base, tgt_ext;
  logic            cnt_clr, cnt_en;

  assign tgt_ext = PC_W'(Target);

  always_comb begin
    case (ProgSel)
      SEL_P2:  sel_base = BASE2;
      SEL_P3:  sel_base = BASE3;
      default: sel_base = BASE1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    base_nxt  = base;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          pc_nxt  = '0;
          cnt_clr = 1'b1;
        end else if (start_q) begin
          // falling edge of Start launches the selected program
          base_nxt  = sel_base;
          pc_nxt    = sel_base;
          cnt_clr   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (Start) begin
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (HaltReq) begin
            state_nxt = HALT;
          end else if (!Stall) begin
            if (BranchEn && Taken) pc_nxt = base + tgt_ext;
            else                   pc_nxt = ProgCtr + PC_W'(1);
          end
        end
      end
      HALT: begin
        if (Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FetchEn/Done are decoded from the next state so they stay pure flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      base    <= '0;
      ProgCtr <= '0;
      FetchEn <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= Start;
      base    <= base_nxt;
      ProgCtr <= pc_nxt;
      FetchEn <= (state_nxt == RUN);
      Done    <= (state_nxt == HALT);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (Clk),
    .rst (Reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (CycleCnt)
  );

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Bench for prog_ctr_seq: default DUT plus a narrow DUT (PC_W=8, CNT_W=4,
// PROG2_BASE=250) on shared stimulus, both checked against a behavioural model.
module tb_prog_ctr_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = 2'd1;
  logic       Stall = 1'b0, BranchEn = 1'b0, Taken = 1'b0, HaltReq = 1'b0;
  logic [7:0] Target = 8'd0;

  logic [9:0]  pc0;
  logic [15:0] cnt0;
  logic        fetch0, done0;
  logic [7:0]  pc1;
  logic [3:0]  cnt1;
  logic        fetch1, done1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  prog_ctr_seq u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .HaltReq(HaltReq),
    .ProgCtr(pc0), .FetchEn(fetch0), .Done(done0), .CycleCnt(cnt0)
  );

  prog_ctr_seq #(.PC_W(8), .CNT_W(4), .PROG2_BASE(250)) u_small (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .HaltReq(HaltReq),
    .ProgCtr(pc1), .FetchEn(fetch1), .Done(done1), .CycleCnt(cnt1)
  );

  // Model: phase 0 idle, 1 running, 2 halted; one slot per configuration.
  int pmod[2] = '{1024, 256};
  int cmax[2] = '{65535, 15};
  int bases[2][4] = '{'{0, 0, 256, 512}, '{0, 0, 250, 0}};
  int m_ph[2]   = '{0, 0};
  int m_pc[2]   = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_base[2] = '{0, 0};
  int m_sq[2]   = '{0, 0};

  task automatic mstep(int c);
    int sel;
    if (Reset) begin
      m_ph[c] = 0; m_pc[c] = 0; m_cnt[c] = 0; m_base[c] = 0; m_sq[c] = 0;
    end else begin
      if (m_ph[c] == 0) begin
        if (Start) begin
          m_pc[c] = 0; m_cnt[c] = 0;
        end else if (m_sq[c] != 0) begin
          sel = (ProgSel == 2'd0) ? 1 : int'(ProgSel);
          m_base[c] = bases[c][sel];
          m_pc[c] = m_base[c]; m_cnt[c] = 0; m_ph[c] = 1;
        end
      end else if (m_ph[c] == 1) begin
        if (Start) m_ph[c] = 0;
        else begin
          if (m_cnt[c] < cmax[c]) m_cnt[c] = m_cnt[c] + 1;
          if (HaltReq) m_ph[c] = 2;
          else if (!Stall) begin
            if (BranchEn && Taken) m_pc[c] = (m_base[c] + int'(Target)) % pmod[c];
            else                   m_pc[c] = (m_pc[c] + 1) % pmod[c];
          end
        end
      end else begin
        if (Start) m_ph[c] = 0;
      end
      m_sq[c] = Start ? 1 : 0;
    end
  endtask

  always @(posedge Clk) begin
    mstep(0);
    mstep(1);
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("pc0",    int'(pc0),    m_pc[0]);
      check("cnt0",   int'(cnt0),   m_cnt[0]);
      check("fetch0", int'(fetch0), (m_ph[0] == 1) ? 1 : 0);
      check("done0",  int'(done0),  (m_ph[0] == 2) ? 1 : 0);
      check("pc1",    int'(pc1),    m_pc[1]);
      check("cnt1",   int'(cnt1),   m_cnt[1]);
      check("fetch1", int'(fetch1), (m_ph[1] == 1) ? 1 : 0);
      check("done1",  int'(done1),  (m_ph[1] == 2) ? 1 : 0);
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic clr_ctl();
    Stall = 0; BranchEn = 0; Taken = 0; HaltReq = 0; Target = 8'd0;
  endtask

  // Returns at the negedge of the first RUN cycle (ProgCtr = base).
  task automatic launch(logic [1:0] sel);
    clr_ctl();
    Start = 1; ProgSel = sel; tick();
    Start = 0; tick();
  endtask

  initial begin
    Reset = 1; tick(); tick();
    chk_en = 1;
    check("rst_pc", int'(pc0), 0);
    check("rst_fetch", int'(fetch0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_cnt", int'(cnt0), 0);
    Reset = 0;

    // reset mid-run
    launch(2'd2); tick(); tick();
    Reset = 1; tick(); tick();
    check("midrst_pc", int'(pc0), 0);
    check("midrst_fetch", int'(fetch0), 0);
    check("midrst_done", int'(done0), 0);
    check("midrst_cnt", int'(cnt0), 0);
    Reset = 0; tick();

    // straight-line program 2, halt in 5th RUN cycle
    launch(2'd2);
    check("p2_first", int'(pc0), 256);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("p2_seq", int'(pc0), 256 + i);
    end
    HaltReq = 1; tick(); HaltReq = 0;
    check("p2_halt_pc", int'(pc0), 260);
    check("p2_done", int'(done0), 1);
    check("p2_fetch", int'(fetch0), 0);
    check("p2_cnt", int'(cnt0), 5);
    tick();
    check("p2_frozen_cnt", int'(cnt0), 5);

    // program 3, taken then not-taken branch
    launch(2'd3);
    tick(); tick(); tick();
    check("p3_pre", int'(pc0), 515);
    BranchEn = 1; Taken = 1; Target = 8'd9; tick();
    check("p3_taken", int'(pc0), 521);
    Taken = 0; Target = 8'd200; tick();
    check("p3_nottaken", int'(pc0), 522);
    clr_ctl();

    // stall over a taken branch, then re-presented branch
    launch(2'd1);
    tick(); tick(); tick(); tick();
    check("st_pc4", int'(pc0), 4);
    Stall = 1; BranchEn = 1; Taken = 1; Target = 8'd104;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold", int'(pc0), 4);
    end
    check("st_cnt", int'(cnt0), 7);
    Stall = 0; tick();
    check("st_branch", int'(pc0), 104);
    check("st_cnt2", int'(cnt0), 8);

    // halt beats branch and stall; relaunch after Done
    HaltReq = 1; BranchEn = 1; Taken = 1; Stall = 1; Target = 8'd50; tick();
    clr_ctl();
    check("hb_pc", int'(pc0), 104);
    check("hb_done", int'(done0), 1);
    check("hb_cnt", int'(cnt0), 9);
    Start = 1; ProgSel = 2'd2; tick();
    check("hb_doneclr", int'(done0), 0);
    Start = 0; tick();
    check("hb_relaunch", int'(pc0), 256);
    check("hb_fetch", int'(fetch0), 1);

    // ProgSel=0 falls back to program 1
    launch(2'd0);
    check("sel0_pc", int'(pc0), 0);
    BranchEn = 1; Taken = 1; Target = 8'd7; tick(); clr_ctl();
    check("sel0_br", int'(pc0), 7);

    // counter saturation on the narrow DUT
    launch(2'd1);
    repeat (20) tick();
    check("sat_big", int'(cnt0), 20);
    check("sat_small", int'(cnt1), 15);

    // PC wrap on the narrow DUT
    launch(2'd2);
    check("wrap_base", int'(pc1), 250);
    repeat (6) tick();
    check("wrap_inc", int'(pc1), 0);
    BranchEn = 1; Taken = 1; Target = 8'd10; tick(); clr_ctl();
    check("wrap_br_small", int'(pc1), 4);
    check("wrap_br_big", int'(pc0), 266);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Reset    = ($urandom_range(0, 299) == 0);
      Start    = ($urandom_range(0, 29) == 0);
      ProgSel  = 2'($urandom_range(0, 3));
      Stall    = ($urandom_range(0, 4) == 0);
      BranchEn = ($urandom_range(0, 3) == 0);
      Taken    = ($urandom_range(0, 1) == 0);
      Target   = 8'($urandom_range(0, 255));
      HaltReq  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
